pipelined_segment_adder: RTL and testbench
==========================================

# pipelined_segment_adder

Parametrised, pipelined add/subtract unit: the successor to the fixed 32-bit two-block carry-chained adder. The operand is split into `WIDTH/SEG` segments; each pipeline stage adds one segment and registers the carry into the next stage, giving one result per cycle at any width. A valid/ready handshake on both sides lets it sit between streaming producers and consumers in the datapath labs.

## Interface
- `WIDTH`, 32: operand/result width; must be a positive multiple of `SEG`.
- `SEG`, 16: segment width per stage; `STAGES = WIDTH/SEG` (≥1).
- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  operand beat present.
- `in_ready`  output  1  unit accepts a beat this cycle.
- `a`  input  WIDTH  operand A.
- `b`  input  WIDTH  operand B.
- `cin`  input  1  carry-in (borrow-in when subtracting).
- `sub`  input  1  0 = add, 1 = subtract.
- `out_valid`  output  1  result beat present.
- `out_ready`  input  1  consumer accepts the result.
- `sum`  output  WIDTH  result.
- `cout`  output  1  carry-out of the MSB segment.
- `ovf`  output  1  signed overflow (present only with `PSA_OVERFLOW_EN`).

## Operation
- Arithmetic: `{cout, sum} = a + (sub ? ~b : b) + (cin ^ sub)`, modulo 2^(WIDTH+1). `sub=1, cin=0` gives a−b; `sub=1, cin=1` gives a−b−1. In subtract mode `cout=1` means no borrow.
- Stage k (0..STAGES−1) adds segment k of A and B' (B after conditional inversion) plus the registered carry from stage k−1 (stage 0 uses `cin^sub`), and registers the SEG-bit partial sum and carry-out.
- Upper segments of A and B' are carried forward in skew registers until their stage; finished lower partial sums are carried forward in deskew registers, so all segments of one beat leave together.
- Each stage has a valid bit; operands are captured only when `in_valid && in_ready`.
- Global stall: `adv = !out_valid || out_ready`. With `adv=1`, every stage shifts one step (bubbles included); with `adv=0`, all stage registers hold. `in_ready = adv`, combinational from `out_valid`/`out_ready` only, never from `in_valid`.
- `sum`, `cout` and `ovf` come straight from the last stage's registers and hold steady while `out_valid && !out_ready`.
- STAGES=1 degenerates to a single registered adder with the same handshake.
- Elaboration error if `WIDTH % SEG != 0` or `SEG < 1`.

## Timing
- Reset (asynchronous assert, synchronous-safe release): all valid bits 0, `out_valid=0`, `sum=0`, `cout=0`, `ovf=0`; `in_ready=1` right after reset.
- Latency: a beat accepted at edge n appears with `out_valid=1` after edge n+STAGES−1, i.e. STAGES cycles after it is presented. WIDTH=32, SEG=16 → 2 cycles.
- Throughput: 1 beat/cycle while `out_ready=1`; up to STAGES beats in flight.
- Simultaneous accept and drain (`out_valid && out_ready && in_valid`): both happen on the same edge; no bubble is inserted.
- Backpressure: `out_ready=0` with `out_valid=1` freezes the whole pipe next cycle. No beat is lost or duplicated, and internal bubbles are not compressed.
- Reset mid-operation: all in-flight beats are discarded immediately; the first post-reset output comes from a beat accepted after reset.
- `sub`/`cin` are sampled with `a`/`b` on the accepting edge; changing them later does not affect a beat in flight.

## Configuration
- `PSA_OVERFLOW_EN` defined: the `ovf` port exists. It is registered alongside the last stage: `ovf = (A'[MSB] == B'[MSB]) && (sum[MSB] != A'[MSB])`, using the post-inversion B'. It is 0 at reset and holds under stall.
- Not defined: no `ovf` port and no overflow logic; all other behaviour is identical.

## Test plan
- WIDTH=32, SEG=16, add, `a=0x0000FFFF`, `b=0x00000001`, `cin=0`, `out_ready=1` → 2 cycles later `sum=0x00010000`, `cout=0` (carry crosses the stage boundary).
- Add `a=0xFFFFFFFF`, `b=0`, `cin=1` → `sum=0x00000000`, `cout=1`. Subtract `a=5`, `b=7`, `cin=0` → `sum=0xFFFFFFFE`, `cout=0` (borrow).
- Back-to-back stream of 8 beats `a=i`, `b=i<<16` with `out_ready=1` → 8 consecutive valid results `i*0x10001`, no gaps, first one at cycle 2.
- Stream with `out_ready` low for 3 cycles mid-stream → `in_ready=0` during the stall, `sum` frozen, all results in order, none dropped or repeated.
- Assert `rst` with 2 beats in flight → `out_valid=0`, `sum=0` immediately; the next accepted beat is the first output.
- `PSA_OVERFLOW_EN`: `a=0x7FFFFFFF + b=1` → `ovf=1`; `a=0x80000000 − b=1` → `ovf=1`; `a=3 + b=4` → `ovf=0`. Repeat the first test at WIDTH=64, SEG=16 → latency 4.

Source files
------------

// File: rtl/pipelined_segment_adder.sv
// rtl/pipelined_segment_adder.sv - segment-per-stage pipelined add/subtract with valid/ready handshake
// Define PSA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module pipelined_segment_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PSA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);
    localparam int STAGES = (SEG > 0) ? (WIDTH / SEG) : 1;

    if (SEG < 1 || WIDTH < 1 || (WIDTH % SEG) != 0) begin : g_bad_cfg
        $error("pipelined_segment_adder: WIDTH must be a positive multiple of SEG");
    end

    logic             adv;
    logic [WIDTH-1:0] b_inv;

    // One global advance: the whole pipe moves together or holds together.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_inv    = sub ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG-1:0]         sa;
        logic [SEG-1:0]         sb;
        logic                   ci;
        logic                   vi;
        logic [SEG:0]           add;
        logic [(k+1)*SEG-1:0]   r_d;
        logic [(k+1)*SEG-1:0]   r_q;
        logic                   v_q;
        logic                   c_q;

        if (k == 0) begin : g_first
            assign sa  = a[SEG-1:0];
            assign sb  = b_inv[SEG-1:0];
            assign ci  = cin ^ sub;
            assign vi  = in_valid;
            assign r_d = add[SEG-1:0];
        end else begin : g_next
            assign sa  = g_stage[k-1].g_skew.a_q[SEG-1:0];
            assign sb  = g_stage[k-1].g_skew.b_q[SEG-1:0];
            assign ci  = g_stage[k-1].c_q;
            assign vi  = g_stage[k-1].v_q;
            assign r_d = {add[SEG-1:0], g_stage[k-1].r_q};
        end

        assign add = {1'b0, sa} + {1'b0, sb} + {{SEG{1'b0}}, ci};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                r_q <= '0;
            end else if (adv) begin
                v_q <= vi;
                if (vi) begin
                    c_q <= add[SEG];
                    r_q <= r_d;
                end
            end
        end

        // Segments not yet summed ride along here until their own stage.
        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-(k+1)*SEG-1:0] a_d;
            logic [WIDTH-(k+1)*SEG-1:0] b_d;
            logic [WIDTH-(k+1)*SEG-1:0] a_q;
            logic [WIDTH-(k+1)*SEG-1:0] b_q;

            if (k == 0) begin : g_src_in
                assign a_d = a[WIDTH-1:SEG];
                assign b_d = b_inv[WIDTH-1:SEG];
            end else begin : g_src_prev
                assign a_d = g_stage[k-1].g_skew.a_q[WIDTH-k*SEG-1:SEG];
                assign b_d = g_stage[k-1].g_skew.b_q[WIDTH-k*SEG-1:SEG];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv && vi) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign sum       = g_stage[STAGES-1].r_q;
    assign cout      = g_stage[STAGES-1].c_q;

`ifdef PSA_OVERFLOW_EN
    logic ovf_d;
    logic ovf_q;

    // The last stage sees the MSBs of A and post-inversion B', so overflow is judged there.
    assign ovf_d = (g_stage[STAGES-1].sa[SEG-1] == g_stage[STAGES-1].sb[SEG-1]) &&
                   (g_stage[STAGES-1].add[SEG-1] != g_stage[STAGES-1].sa[SEG-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv && g_stage[STAGES-1].vi) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// tb/tb_pipelined_segment_adder.sv - directed self-checking bench for pipelined_segment_adder
// Exercises a 32/16 instance throughout and a 64/16 instance for latency; ovf checks follow PSA_OVERFLOW_EN.
module tb_pipelined_segment_adder;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [63:0] w_a;
    logic [63:0] w_b;
    logic        w_out_valid;
    logic [63:0] w_sum;
    logic        w_cout;

`ifdef PSA_OVERFLOW_EN
    logic        ovf;
    logic        w_ovf;
`endif

    int n_checks;
    int n_fail;

    pipelined_segment_adder #(.WIDTH(32), .SEG(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PSA_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    pipelined_segment_adder #(.WIDTH(64), .SEG(16)) dut64 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .a         (w_a),
        .b         (w_b),
        .cin       (1'b0),
        .sub       (1'b0),
        .out_valid (w_out_valid),
        .out_ready (1'b1),
        .sum       (w_sum),
        .cout      (w_cout)
`ifdef PSA_OVERFLOW_EN
        ,
        .ovf       (w_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (sum !== 32'h0) begin n_fail++; $display("FAIL reset_sum got=%h exp=00000000", sum); end
        n_checks++;
        if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got=%b exp=0", cout); end
`ifdef PSA_OVERFLOW_EN
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
        rst = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++;
        if (w_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_w_out_valid got=%b exp=0", w_out_valid); end
    endtask

    task automatic test_basic;
        logic [31:0] va [9] = '{32'h0000FFFF, 32'hFFFFFFFF, 32'h5, 32'h7, 32'h5,
                                32'h12345678, 32'h7FFFFFFF, 32'h80000000, 32'h3};
        logic [31:0] vb [9] = '{32'h1, 32'h0, 32'h7, 32'h5, 32'h7,
                                32'h9ABCDEF0, 32'h1, 32'h1, 32'h4};
        logic        vc [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        vs [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] es [9] = '{32'h00010000, 32'h0, 32'hFFFFFFFE, 32'h2, 32'hFFFFFFFD,
                                32'hACF13568, 32'h80000000, 32'h7FFFFFFF, 32'h7};
        logic        ec [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        eo [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i];
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic%0d_in_ready got=%b exp=1", i, in_ready); end
            tick();
            in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'hDEADBEEF; cin = ~vc[i]; sub = ~vs[i];
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic%0d_early_valid got=%b exp=0", i, out_valid); end
            tick();
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic%0d_valid got=%b exp=1", i, out_valid); end
            n_checks++;
            if (sum !== es[i]) begin n_fail++; $display("FAIL basic%0d_sum got=%h exp=%h", i, sum, es[i]); end
            n_checks++;
            if (cout !== ec[i]) begin n_fail++; $display("FAIL basic%0d_cout got=%b exp=%b", i, cout, ec[i]); end
`ifdef PSA_OVERFLOW_EN
            n_checks++;
            if (ovf !== eo[i]) begin n_fail++; $display("FAIL basic%0d_ovf got=%b exp=%b", i, ovf, eo[i]); end
`else
            if (eo[i] === 1'bx) $display("unreachable");
`endif
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic%0d_drained got=%b exp=0", i, out_valid); end
        end
        cin = 1'b0; sub = 1'b0;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (cyc < 8) begin
                in_valid = 1'b1; a = 32'(cyc); b = 32'(cyc) << 16;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (cyc >= 1 && cyc <= 8) begin
                n_checks++;
                if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid cyc=%0d got=%b exp=1", cyc, out_valid); end
                n_checks++;
                if (sum !== 32'(cyc - 1) * 32'h10001) begin
                    n_fail++; $display("FAIL b2b_sum cyc=%0d got=%h exp=%h", cyc, sum, 32'(cyc - 1) * 32'h10001);
                end
            end else begin
                n_checks++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle cyc=%0d got=%b exp=0", cyc, out_valid); end
            end
        end
    endtask

    task automatic test_backpressure;
        int          sent = 0;
        int          rcv = 0;
        logic [31:0] frozen = '0;
        cin = 1'b0; sub = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (sent < 6);
            a = 32'h100 + 32'(sent);
            b = 32'(sent) << 8;
            #1;
            if (cyc >= 3 && cyc <= 5) begin
                n_checks++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
                if (cyc == 3) frozen = sum;
                else begin
                    n_checks++;
                    if (sum !== frozen) begin n_fail++; $display("FAIL bp_frozen cyc=%0d got=%h exp=%h", cyc, sum, frozen); end
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (rcv >= 6) begin
                    n_fail++; $display("FAIL bp_extra got=%h exp=none", sum);
                end else if (sum !== (32'h100 + 32'(rcv)) + (32'(rcv) << 8)) begin
                    n_fail++; $display("FAIL bp_order idx=%0d got=%h exp=%h", rcv, sum, (32'h100 + 32'(rcv)) + (32'(rcv) << 8));
                end
                rcv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (rcv !== 6) begin n_fail++; $display("FAIL bp_count got=%0d exp=6", rcv); end
    endtask

    task automatic test_reset_midflight;
        out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; a = 32'h11; b = 32'h22;
        tick();
        a = 32'h33; b = 32'h44;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (sum !== 32'h0) begin n_fail++; $display("FAIL rstmid_sum got=%h exp=00000000", sum); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_ghost i=%0d got=%b exp=0", i, out_valid); end
        end
        in_valid = 1'b1; a = 32'h1000; b = 32'h0234;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_early got=%b exp=0", out_valid); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_first_valid got=%b exp=1", out_valid); end
        n_checks++;
        if (sum !== 32'h1234) begin n_fail++; $display("FAIL rstmid_first_sum got=%h exp=00001234", sum); end
        tick();
    endtask

    task automatic test_wide;
        logic [63:0] wa [2] = '{64'h0000_0000_0000_FFFF, 64'h0000_FFFF_FFFF_FFFF};
        logic [63:0] ws [2] = '{64'h0000_0000_0001_0000, 64'h0001_0000_0000_0000};
        for (int i = 0; i < 2; i++) begin
            w_in_valid = 1'b1; w_a = wa[i]; w_b = 64'h1;
            for (int c = 1; c <= 4; c++) begin
                tick();
                w_in_valid = 1'b0;
                n_checks++;
                if (w_out_valid !== (c == 4)) begin
                    n_fail++; $display("FAIL wide%0d_latency edge=%0d got=%b exp=%b", i, c, w_out_valid, (c == 4));
                end
            end
            n_checks++;
            if (w_sum !== ws[i]) begin n_fail++; $display("FAIL wide%0d_sum got=%h exp=%h", i, w_sum, ws[i]); end
            n_checks++;
            if (w_cout !== 1'b0) begin n_fail++; $display("FAIL wide%0d_cout got=%b exp=0", i, w_cout); end
            n_checks++;
            if (w_in_ready !== 1'b1) begin n_fail++; $display("FAIL wide%0d_in_ready got=%b exp=1", i, w_in_ready); end
            tick();
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_a = '0; w_b = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
